// File: rtl/lock_pkg.sv
// Shared types and width helpers for the serial code lock.
// Contents:
//   state_t   - lock FSM state encoding
//   cnt_width - bits needed to hold a count of 0..n, never less than 1
//   DEF_*     - default parameter values and the widths derived from them
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COLLECT  = 3'd1,
        UNLOCKED = 3'd2,
        FAIL     = 3'd3,
        LOCKOUT  = 3'd4
    } state_t;

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int DEF_CODE_LEN       = 4;
    localparam int DEF_MAX_FAILS      = 3;
    localparam int DEF_LOCKOUT_CYCLES = 16;
    localparam int DEF_TIMEOUT_CYCLES = 8;

    localparam int DEF_BIT_CNT_W  = cnt_width(DEF_CODE_LEN);
    localparam int DEF_FAIL_CNT_W = $clog2(DEF_MAX_FAILS + 1);
    localparam int DEF_TIMER_W    = cnt_width(max2(DEF_LOCKOUT_CYCLES, DEF_TIMEOUT_CYCLES));

endpackage

// File: rtl/lock_timer.sv
// Shared up-counter used for both the inter-bit timeout and the lockout
// duration. The two uses never overlap, so one counter serves both.
// Ports:
//   clk, rstn - clock, asynchronous active-low reset
//   clr       - synchronous clear to 0 (wins over inc)
//   inc       - count up by one
//   tc        - terminal count to compare against
//   at_tc     - high while the count equals tc
module lock_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] tc,
    output logic         at_tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign at_tc = (cnt_q == tc);

endmodule

// File: rtl/serial_code_lock.sv
// Serial unlock checker. Collects a full CODE_LEN-bit code (MSB first) before
// giving any verdict, compares it against code_i, counts consecutive failures,
// enforces a timed lockout after MAX_FAILS failures and aborts stalled entries.
// Ports:
//   clk, rstn    - clock, asynchronous active-low reset
//   ser_val      - one serial bit accepted per cycle when high
//   ser_data     - serial bit value
//   code_i       - expected code, sampled on the final-bit edge
//   output_val   - verdict valid (UNLOCKED, FAIL, LOCKOUT)
//   output_data  - 1 = unlocked
//   locked_out   - high while in lockout
//   fail_cnt     - consecutive-failure count
module serial_code_lock
    import lock_pkg::*;
#(
    parameter int CODE_LEN       = DEF_CODE_LEN,
    parameter int MAX_FAILS      = DEF_MAX_FAILS,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           ser_val,
    input  logic                           ser_data,
    input  logic [CODE_LEN-1:0]            code_i,
    output logic                           output_val,
    output logic                           output_data,
    output logic                           locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);

    localparam int  BW = cnt_width(CODE_LEN);
    localparam int  FW = $clog2(MAX_FAILS + 1);
    localparam int  TW = cnt_width(max2(LOCKOUT_CYCLES, TIMEOUT_CYCLES));
    localparam int  SW = CODE_LEN - 1;  // the final bit comes straight from ser_data
    localparam bit  TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    localparam logic [BW-1:0] LAST_BIT   = BW'(CODE_LEN - 1);
    localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_FAILS);
    localparam logic [FW-1:0] FAIL_LAST  = FW'(MAX_FAILS - 1);
    localparam logic [TW-1:0] TC_LOCKOUT = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] TC_TIMEOUT = TIMEOUT_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;

    state_t         state_q, state_d;
    logic [SW-1:0]  shreg_q, shreg_d;
    logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [FW-1:0]  fail_cnt_q, fail_cnt_d;
    logic           attempt_fail;

    logic           tmr_clr, tmr_inc, tmr_at_tc;
    logic [TW-1:0]  tmr_tc;

    // Timer terminal count is TC-1 so the transition fires on the TC-th cycle.
    assign tmr_tc = (state_q == LOCKOUT) ? TC_LOCKOUT : TC_TIMEOUT;

    // Clear on every state change, outside the two timed states, and on each
    // accepted bit (an arriving bit always beats an expiring timeout).
    assign tmr_clr = (state_d != state_q)
                  || ((state_q != COLLECT) && (state_q != LOCKOUT))
                  || ((state_q == COLLECT) && ser_val);
    assign tmr_inc = (state_q == LOCKOUT)
                  || ((state_q == COLLECT) && !ser_val && TIMEOUT_EN);

    lock_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (tmr_clr),
        .inc   (tmr_inc),
        .tc    (tmr_tc),
        .at_tc (tmr_at_tc)
    );

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        attempt_fail = 1'b0;

        case (state_q)
            IDLE: begin
                if (ser_val) begin
                    shreg_d    = '0;
                    shreg_d[0] = ser_data;
                    bit_cnt_d  = BW'(1);
                    state_d    = COLLECT;
                end
            end
            COLLECT: begin
                if (ser_val) begin
                    shreg_d    = shreg_q << 1;
                    shreg_d[0] = ser_data;
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        if ({shreg_q, ser_data} == code_i) begin
                            fail_cnt_d = '0;
                            state_d    = UNLOCKED;
                        end else begin
                            attempt_fail = 1'b1;
                        end
                    end
                end else if (TIMEOUT_EN && tmr_at_tc) begin
                    attempt_fail = 1'b1;
                end
            end
            UNLOCKED, FAIL: begin
                if (ser_val) state_d = IDLE;
            end
            LOCKOUT: begin
                if (tmr_at_tc) begin
                    fail_cnt_d = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Mismatch and timeout share one failure path; the count saturates
        // at MAX_FAILS because reaching it always enters lockout.
        if (attempt_fail) begin
            bit_cnt_d = '0;
            if (fail_cnt_q >= FAIL_LAST) begin
                fail_cnt_d = FAIL_MAX;
                state_d    = LOCKOUT;
            end else begin
                fail_cnt_d = fail_cnt_q + 1'b1;
                state_d    = FAIL;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            fail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        output_val  = 1'b0;
        output_data = 1'b0;
        locked_out  = 1'b0;
        case (state_q)
            UNLOCKED: begin
                output_val  = 1'b1;
                output_data = 1'b1;
            end
            FAIL:    output_val = 1'b1;
            LOCKOUT: begin
                output_val = 1'b1;
                locked_out = 1'b1;
            end
            default: ;
        endcase
    end

    assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_serial_code_lock.sv
module tb_serial_code_lock;

    logic       clk = 1'b0;
    logic       rstn;
    logic       ser_val;
    logic       ser_data;
    logic [3:0] code_i;
    logic       output_val, output_data, locked_out;
    logic [1:0] fail_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_code_lock #(
        .CODE_LEN(4), .MAX_FAILS(3), .LOCKOUT_CYCLES(16), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .ser_val     (ser_val),
        .ser_data    (ser_data),
        .code_i      (code_i),
        .output_val  (output_val),
        .output_data (output_data),
        .locked_out  (locked_out),
        .fail_cnt    (fail_cnt)
    );

    // exp = {output_val, output_data, locked_out, fail_cnt[1:0]}
    typedef struct packed {
        logic       v;
        logic       d;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic d, input logic val,
                                input logic dat, input logic lk, input logic [1:0] fc);
        vec_t r;
        r.v   = v;
        r.d   = d;
        r.exp = {val, dat, lk, fc};
        return r;
    endfunction

    task automatic step(input logic v, input logic d);
        ser_val  = v;
        ser_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [4:0] exp);
        logic [4:0] act;
        act = {output_val, output_data, locked_out, fail_cnt};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got{val,dat,lk,fc}=%b expected=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic send_code(input logic [3:0] c);
        logic [3:0] cc;
        cc = c;
        for (int i = 3; i >= 0; i--) step(1'b1, cc[i]);
    endtask

    initial begin
        int lk_cycles;
        rstn     = 1'b0;
        ser_val  = 1'b0;
        ser_data = 1'b0;
        code_i   = 4'b1011;

        // Test 1: 1011 with idle gaps
        tbl.push_back(mk(1,1, 0,0,0,2'd0));
        tbl.push_back(mk(0,0, 0,0,0,2'd0));
        tbl.push_back(mk(1,0, 0,0,0,2'd0));
        tbl.push_back(mk(0,0, 0,0,0,2'd0));
        tbl.push_back(mk(0,0, 0,0,0,2'd0));
        tbl.push_back(mk(1,1, 0,0,0,2'd0));
        tbl.push_back(mk(0,0, 0,0,0,2'd0));
        tbl.push_back(mk(0,0, 0,0,0,2'd0));
        tbl.push_back(mk(0,0, 0,0,0,2'd0));
        tbl.push_back(mk(1,1, 1,1,0,2'd0));
        tbl.push_back(mk(0,0, 1,1,0,2'd0));
        tbl.push_back(mk(1,0, 0,0,0,2'd0));
        // Test 2: wrong first bit 0111
        tbl.push_back(mk(1,0, 0,0,0,2'd0));
        tbl.push_back(mk(1,1, 0,0,0,2'd0));
        tbl.push_back(mk(1,1, 0,0,0,2'd0));
        tbl.push_back(mk(1,1, 1,0,0,2'd1));
        tbl.push_back(mk(0,0, 1,0,0,2'd1));
        tbl.push_back(mk(1,1, 0,0,0,2'd1));
        // Test 6: second failure, unlock clears count, next failure gives 1
        tbl.push_back(mk(1,0, 0,0,0,2'd1));
        tbl.push_back(mk(1,0, 0,0,0,2'd1));
        tbl.push_back(mk(1,0, 0,0,0,2'd1));
        tbl.push_back(mk(1,0, 1,0,0,2'd2));
        tbl.push_back(mk(1,0, 0,0,0,2'd2));
        tbl.push_back(mk(1,1, 0,0,0,2'd2));
        tbl.push_back(mk(1,0, 0,0,0,2'd2));
        tbl.push_back(mk(1,1, 0,0,0,2'd2));
        tbl.push_back(mk(1,1, 1,1,0,2'd0));
        tbl.push_back(mk(1,1, 0,0,0,2'd0));
        tbl.push_back(mk(1,1, 0,0,0,2'd0));
        tbl.push_back(mk(1,1, 0,0,0,2'd0));
        tbl.push_back(mk(1,1, 0,0,0,2'd0));
        tbl.push_back(mk(1,1, 1,0,0,2'd1));
        tbl.push_back(mk(1,0, 0,0,0,2'd1));

        #12;
        chk("reset_state", 5'b00000);
        @(negedge clk);
        rstn = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d);
            chk($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Test 5: async reset mid-COLLECT (fail_cnt is 1 here)
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        chk("pre_reset", 5'b00001);
        #2 rstn = 1'b0;
        #1 chk("async_reset", 5'b00000);
        @(posedge clk);
        #1 chk("held_reset", 5'b00000);
        @(negedge clk);
        rstn = 1'b1;
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        chk("post_reset_no_verdict", 5'b00000);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("post_reset_unlock", 5'b11000);
        step(1'b1, 1'b0);
        chk("post_reset_discard", 5'b00000);

        // Test 4a: 2 bits then 8 idle cycles -> timeout failure
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0);
        chk("timeout_not_yet", 5'b00000);
        step(1'b0, 1'b0);
        chk("timeout_fail", 5'b10001);
        step(1'b1, 1'b0);
        chk("timeout_discard", 5'b00001);

        // Test 4b: 7 idle cycles then the remaining bits -> unlock
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0);
        chk("idle7_collecting", 5'b00001);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("idle7_unlock", 5'b11000);
        step(1'b1, 1'b0);
        chk("idle7_discard", 5'b00000);

        // Test 3: three wrong codes -> 16-cycle lockout
        send_code(4'b0000);
        chk("lk_fail1", 5'b10001);
        step(1'b1, 1'b0);
        send_code(4'b0000);
        chk("lk_fail2", 5'b10010);
        step(1'b1, 1'b0);
        send_code(4'b0000);
        chk("lk_enter", 5'b10111);
        lk_cycles = 1;
        for (int i = 1; i <= 15; i++) begin
            step(1'b1, i[0]);
            if (locked_out) lk_cycles++;
            if (i == 8) chk("lk_mid", 5'b10111);
        end
        step(1'b0, 1'b0);
        chk("lk_exit", 5'b00000);
        checks++;
        if (lk_cycles != 16) begin
            failures++;
            $display("FAIL lk_duration got=%0d expected=16", lk_cycles);
        end
        send_code(4'b1011);
        chk("lk_then_unlock", 5'b11000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
